acumulador_sat: RTL
===================

# acumulador_sat

Sequential saturating accumulator that consumes a stream of signed W-bit terms, such as products or partial sums, and emits one saturated W-bit sum per block of N accepted terms. It uses the same two's-complement saturation limits as the combinational saturating adder, 0x0FFFFFF and 0x1000000 for W=25. The accumulated sum is re-saturated after every term. It sits at the output end of the datapath, collapsing a term stream into a per-block result with a valid pulse for the next stage.

## Interface
- W, 25: data width in bits, two's complement.
- N, 8: terms per block, range 1..255.
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- In_valid  in  1  In_data is accepted on this edge; no backpressure, every asserted cycle is one term.
- In_data  in  W  signed term.
- Clear  in  1  synchronous abort of the block in progress.
- Out_data  out  W  signed saturated block sum; holds its value between blocks.
- Out_valid  out  1  one-cycle pulse; Out_data is new this cycle.
- Busy  out  1  high while a block is partially accumulated (count != 0).
- Ovf  out  1  sticky saturation flag; constant 0 unless STICKY_OVF_EN is defined.

## Operation
- Internal registers:
  - acc, W bits, signed.
  - count, 8 bits.
- States are implied by count:
  - IDLE: count == 0, acc == 0.
  - ACC: 1 <= count <= N-1.
- Step arithmetic:
  - s = sign-extend(acc) + sign-extend(In_data), computed in W+1 bits.
  - sat(s) = 2^(W-1)-1 if s > 2^(W-1)-1.
  - sat(s) = -2^(W-1) if s < -2^(W-1).
  - Otherwise sat(s) = s[W-1:0].
- Saturation is applied at every step and is not undone by later terms. Example: max, then -1, gives max-1.
- Per-edge priority, highest first:
  - Reset: acc=0, count=0, Out_data=0, Out_valid=0, Ovf=0.
  - Clear: acc=0, count=0, Out_valid=0, Ovf=0. Out_data is held. Any In_valid in the same cycle is discarded.
  - In_valid with count == N-1:
    - Out_data <= sat(acc+In_data).
    - Out_valid <= 1.
    - acc <= 0, count <= 0.
  - In_valid otherwise: acc <= sat(acc+In_data), count <= count+1.
  - No In_valid: acc and count held.
- Out_valid is 0 on every edge that does not complete a block.
- N == 1: every accepted term produces Out_data = In_data, since sat(0+x) = x.
- Busy = (count != 0), decoded combinationally from the registered count.

## Timing
- Reset values: Out_data=0, Out_valid=0, Busy=0, Ovf=0.
- Latency: Out_valid is high in the cycle immediately after the edge that accepts the N-th term, for exactly one cycle.
- Back-to-back blocks:
  - In_valid may be asserted in the same cycle as Out_valid; that term is the first of the next block.
  - No bubble is required.
  - Throughput is one block per N valid cycles.
- Gaps in In_valid are allowed. The block completes on the N-th accepted term regardless of idle cycles.
- Clear or Reset mid-block: the partial sum is discarded and no Out_valid is produced for it.
- Clear in the cycle after a completion does not retract an Out_valid that is already high. Out_valid clears on that edge as usual.

## Configuration
- STICKY_OVF_EN defined:
  - Ovf is a register, set on any edge where a step saturates, including the final step.
  - Ovf is cleared only by Reset or Clear; it persists across block boundaries.
  - Ovf is visible in the cycle after the saturating edge, so it is valid together with Out_valid for a final-step saturation.
- STICKY_OVF_EN not defined:
  - Ovf is tied to 0.
  - No flag register is inferred.
  - Saturation behaviour is otherwise identical.

## Test plan
- Basic sum. Reset, N=8, inputs 1..8 on consecutive cycles -> Out_data=36 (0x0000024) with a one-cycle Out_valid the cycle after the 8th term. Busy is high from the cycle after the 1st term until Out_valid. Ovf=0.
- Positive saturation. 8 terms of 0x0800000 -> Out_data=0x0FFFFFF. With STICKY_OVF_EN, Ovf=1 after the 2nd term and stays 1 until Clear.
- Negative saturation. 8 terms of 0x1000000 -> Out_data=0x1000000. Ovf=1 with the macro, 0 without it.
- Non-reversibility. Terms 0x0FFFFFF, 0x0000001, 0x1FFFFFF, then five 0 -> Out_data=0x0FFFFFE, not 0x0FFFFFF.
- Abort and gaps. Three terms of 5, then Clear asserted together with In_valid=1 and In_data=7, then eight terms of 2 with idle cycles between them:
  - No Out_valid for the aborted block; the 7 is discarded.
  - The final block gives Out_data=16.
  - Out_data holds its previous value throughout.
- Back-to-back blocks. 16 consecutive valid terms of 1 -> two Out_valid pulses, 8 cycles apart, each with Out_data=8 (0x0000008). Reset asserted at term 12 -> no second pulse and all outputs 0.

Source files
------------

// File: rtl/acumulador_sat_if.sv
// Term-stream / block-sum bus for acumulador_sat.
// The master drives the terms and the clear; the slave (the accumulator) returns the results.
interface acumulador_sat_if #(
  parameter int W = 25
);
  logic                in_valid;
  logic signed [W-1:0] in_data;
  logic                clear;
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                busy;
  logic                ovf;

  modport master (
    output in_valid, in_data, clear,
    input  out_data, out_valid, busy, ovf
  );

  modport slave (
    input  in_valid, in_data, clear,
    output out_data, out_valid, busy, ovf
  );
endinterface

// File: rtl/acumulador_sat.sv
// Saturating block accumulator: sums N signed terms, re-saturating after every term.
// Optional macro STICKY_OVF_EN adds a sticky saturation flag on ovf; without it ovf is tied to 0.
module acumulador_sat #(
  parameter int W = 25,
  parameter int N = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  acumulador_sat_if.slave bus
);

  localparam logic [7:0] LAST = 8'(N - 1);

  logic signed [W-1:0] acc_q, acc_d;
  logic        [7:0]   cnt_q, cnt_d;
  logic signed [W-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W:0]   sum;
  logic signed [W-1:0] sum_sat;

  // Clamp a W+1-bit sum to the W-bit range; the top two bits differ only on overflow.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] s);
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  assign sum     = {acc_q[W-1], acc_q} + {bus.in_data[W-1], bus.in_data};
  assign sum_sat = sat_w(sum);

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (bus.clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (bus.in_valid) begin
      if (cnt_q == LAST) begin
        out_data_d  = sum_sat;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef STICKY_OVF_EN
  logic ovf_q, ovf_d;

  function automatic logic is_sat(input logic signed [W:0] s);
    return s[W] != s[W-1];
  endfunction

  // Flag survives block boundaries; only clear or reset drops it.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.clear)
      ovf_d = 1'b0;
    else if (bus.in_valid && is_sat(sum))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (cnt_q != 8'd0);

endmodule
